// File: rtl/add_sched_pkg.sv
// add_sched_pkg: shared FSM encoding and default nibble count for the nibble adder scheduler.
package add_sched_pkg;
  localparam int NIB_DEF = 4;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
endpackage

// File: rtl/add4_nib.sv
// add4_nib: combinational 4-bit ripple-carry adder.
module add4_nib (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] w_c;
  assign w_c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end
  assign cout = w_c[4];
endmodule

// File: rtl/nibble_add_sched.sv
// nibble_add_sched: two-requester round-robin scheduler feeding a nibble-serial adder.
module nibble_add_sched
  import add_sched_pkg::*;
#(
  parameter  int NIB = NIB_DEF,
  localparam int W   = 4 * NIB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_id,
  output logic         busy
);
  localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
  state_t        r_state;
  logic [W-1:0]  r_a, r_b, r_sum;
  logic [IW-1:0] r_idx;
  logic          r_c, r_cout, r_id, r_pri, r_valid;
  logic          w_idle, w_acc, w_id, w_co;
  logic [3:0]    w_s;
  // r_pri names the requester that wins the next tie
  assign w_idle     = (r_state == IDLE) & ~rst;
  assign req0_ready = w_idle & req0_valid & (~req1_valid | ~r_pri);
  assign req1_ready = w_idle & req1_valid & (~req0_valid | r_pri);
  assign w_acc      = req0_ready | req1_ready;
  assign w_id       = req1_ready;
  assign rsp_valid  = r_valid;
  assign rsp_sum    = r_sum;
  assign rsp_cout   = r_cout;
  assign rsp_id     = r_id;
  assign busy       = r_state != IDLE;
  add4_nib u_add (
    .a(r_a[r_idx*4 +: 4]),
    .b(r_b[r_idx*4 +: 4]),
    .cin(r_c),
    .s(w_s),
    .cout(w_co)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_id    <= 1'b0;
      r_pri   <= 1'b0;
      r_valid <= 1'b0;
    end else
      case (r_state)
        IDLE: if (w_acc) begin
          r_a     <= w_id ? req1_a : req0_a;
          r_b     <= w_id ? req1_b : req0_b;
          r_id    <= w_id;
          r_pri   <= ~w_id;
          r_idx   <= '0;
          r_c     <= 1'b0;
          r_state <= ADD;
        end
        ADD: begin
          r_sum[r_idx*4 +: 4] <= w_s;
          r_c                 <= w_co;
          r_idx               <= r_idx + 1'b1;
          if (r_idx == IW'(NIB - 1)) begin
            r_cout  <= w_co;
            r_state <= DONE;
          end
        end
        DONE: if (!r_valid) r_valid <= 1'b1;
        else if (rsp_ready) begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
endmodule

// File: tb/tb_nibble_add_sched.sv
// tb_nibble_add_sched: randomized and directed checks against an arithmetic round-robin model.
module tb_nibble_add_sched;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;
  logic         clk = 1'b0, rst = 1'b1;
  logic         req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         rsp_valid, rsp_ready = 0, rsp_cout, rsp_id, busy;
  logic [W-1:0] rsp_sum;
  int           n_chk = 0, n_err = 0;
  bit           m_pri = 0;
  nibble_add_sched #(.NIB(NIB)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input bit v0, input bit v1, input logic [W-1:0] a0, input logic [W-1:0] b0,
                     input logic [W-1:0] a1, input logic [W-1:0] b1, input int hold, input bit drop);
    int g, lat, s;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    rsp_ready = 0;
    #1;
    g = (v0 && v1) ? int'(m_pri) : (v1 ? 1 : 0);
    s = g ? int'(a1) + int'(b1) : int'(a0) + int'(b0);
    chk("rdy0", req0_ready, g == 0);
    chk("rdy1", req1_ready, g == 1);
    step();
    m_pri = (g == 0);
    if (drop) begin
      req0_valid = 0;
      req1_valid = 0;
    end
    req0_a = W'($urandom); req0_b = W'($urandom); req1_a = W'($urandom); req1_b = W'($urandom);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!rsp_valid && lat < 20);
    chk("latency", lat, NIB + 1);
    chk("sum", rsp_sum, s[W-1:0]);
    chk("cout", rsp_cout, s[W]);
    chk("id", rsp_id, g);
    for (int k = 0; k < hold; k++) begin
      step();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_sum", rsp_sum, s[W-1:0]);
      chk("hold_rdy", {req0_ready, req1_ready}, 0);
      chk("hold_busy", busy, 1);
    end
    rsp_ready = 1;
    step();
    chk("hs_valid", rsp_valid, 0);
    chk("hs_busy", busy, 0);
    rsp_ready = 0;
  endtask
  initial begin
    step();
    step();
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", rsp_sum, 0);
    rst = 0;
    step();
    chk("idle_rdy", {req0_ready, req1_ready}, 0);
    txn(1, 0, 16'h1234, 16'h4321, 16'h0, 16'h0, 0, 1);
    txn(0, 1, 16'h0, 16'h0, 16'hFFFF, 16'h0001, 0, 1);
    rst = 1;
    step();
    rst = 0;
    m_pri = 0;
    step();
    for (int n = 0; n < 3; n++) txn(1, 1, 16'h0001, 16'h0001, 16'h8000, 16'h8000, 0, 0);
    txn(1, 0, 16'hA5A5, 16'h5A5A, 16'h0, 16'h0, 3, 1);
    req0_valid = 0;
    req1_valid = 1; req1_a = 16'h00FF; req1_b = 16'h0001;
    #1;
    step();
    step();
    req0_valid = 1;
    rst = 1;
    #1;
    chk("ar_valid", rsp_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_rdy", {req0_ready, req1_ready}, 0);
    chk("ar_sum", rsp_sum, 0);
    chk("ar_cout", rsp_cout, 0);
    chk("ar_id", rsp_id, 0);
    step();
    req0_valid = 0;
    req1_valid = 0;
    rst = 0;
    m_pri = 0;
    for (int n = 0; n < 8; n++) begin
      step();
      chk("no_rsp", rsp_valid, 0);
    end
    txn(1, 0, 16'h0003, 16'h0004, 16'h0, 16'h0, 0, 1);
    for (int n = 0; n < 25; n++) begin
      bit v0, v1;
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v1 = 1;
      txn(v0, v1, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
          int'($urandom_range(0, 3)), 1'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
